// File: rtl/id_decode_stage_if.sv
// IF -> ID -> EX handshake bundle for the registered RV32I decode stage.
// The stage uses the slave modport; the fetch/execute side uses master.
interface id_decode_stage_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic              out_jal;
    logic              out_jalr;
    logic              out_mem_to_reg;
    logic              out_load_npc;
    logic              out_alu_src1;
    logic [2:0]        out_reg_write;
    logic [3:0]        out_mem_write;
    logic [1:0]        out_reg_read;
    logic [2:0]        out_branch_type;
    logic [3:0]        out_alu_ctrl;
    logic [1:0]        out_alu_src2;
    logic [2:0]        out_imm_type;
    logic [3:0]        out_md_op;
    logic              out_illegal;
    logic [CNT_W-1:0]  illegal_cnt;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
        input  out_jal, out_jalr, out_mem_to_reg, out_load_npc, out_alu_src1,
        input  out_reg_write, out_mem_write, out_reg_read, out_branch_type,
        input  out_alu_ctrl, out_alu_src2, out_imm_type, out_md_op, out_illegal,
        input  illegal_cnt
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
        output out_jal, out_jalr, out_mem_to_reg, out_load_npc, out_alu_src1,
        output out_reg_write, out_mem_write, out_reg_read, out_branch_type,
        output out_alu_ctrl, out_alu_src2, out_imm_type, out_md_op, out_illegal,
        output illegal_cnt
    );
endinterface

// File: rtl/id_decode_stage.sv
// Registered RV32I decode stage: combinational decode into an output register
// backed by a one-entry skid buffer. Define RV32M_EN to accept M-extension ops.
module id_decode_stage #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input logic              CPU_CLK,
    input logic              CPU_RST,
    id_decode_stage_if.slave bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;

    localparam logic [2:0] RW_NONE = 3'd0, RW_LB = 3'd1, RW_LH = 3'd2, RW_LW = 3'd3;
    localparam logic [2:0] RW_LBU  = 3'd4, RW_LHU = 3'd5;
    localparam logic [2:0] BR_BEQ = 3'd1, BR_BNE = 3'd2, BR_BLT = 3'd3;
    localparam logic [2:0] BR_BLTU = 3'd4, BR_BGE = 3'd5, BR_BGEU = 3'd6;
    localparam logic [2:0] IMM_R = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5;
    localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_SRA = 4'd2, ALU_ADD = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd4, ALU_XOR = 4'd5, ALU_OR = 4'd6, ALU_AND = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_LUI = 4'd10;
    localparam logic [1:0] SRC2_REG = 2'd0, SRC2_SHAMT = 2'd1, SRC2_IMM = 2'd2;
    localparam logic [6:0] F7_ZERO = 7'b0000000, F7_ALT = 7'b0100000, F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            jal;
        logic            jalr;
        logic            mem_to_reg;
        logic            load_npc;
        logic            alu_src1;
        logic [2:0]      reg_write;
        logic [3:0]      mem_write;
        logic [1:0]      reg_read;
        logic [2:0]      branch_type;
        logic [3:0]      alu_ctrl;
        logic [1:0]      alu_src2;
        logic [2:0]      imm_type;
        logic [3:0]      md_op;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_t;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       ill_s;
    bundle_t    dec_s;
    logic       accept_s;
    logic       drain_s;

    state_t           state_q, state_d;
    bundle_t          main_q, main_d;
    bundle_t          skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign opcode_s = bus.in_instr[6:0];
    assign funct3_s = bus.in_instr[14:12];
    assign funct7_s = bus.in_instr[31:25];

    // Instruction decode; anything unrecognised collapses to a side-effect-free bundle.
    always_comb begin
        dec_s     = '0;
        dec_s.pc  = bus.in_pc;
        dec_s.rd  = bus.in_instr[11:7];
        dec_s.rs1 = bus.in_instr[19:15];
        dec_s.rs2 = bus.in_instr[24:20];
        ill_s     = 1'b0;
        case (opcode_s)
            OPC_LUI: begin
                dec_s.reg_write = RW_LW;
                dec_s.imm_type  = IMM_U;
                dec_s.alu_src2  = SRC2_IMM;
                dec_s.alu_ctrl  = ALU_LUI;
            end
            OPC_AUIPC: begin
                dec_s.reg_write = RW_LW;
                dec_s.imm_type  = IMM_U;
                dec_s.alu_src1  = 1'b1;
                dec_s.alu_src2  = SRC2_IMM;
                dec_s.alu_ctrl  = ALU_ADD;
            end
            OPC_JAL: begin
                dec_s.jal       = 1'b1;
                dec_s.load_npc  = 1'b1;
                dec_s.reg_write = RW_LW;
                dec_s.imm_type  = IMM_J;
            end
            OPC_JALR: begin
                dec_s.jalr      = 1'b1;
                dec_s.load_npc  = 1'b1;
                dec_s.reg_write = RW_LW;
                dec_s.reg_read  = 2'b10;
                dec_s.imm_type  = IMM_I;
                dec_s.alu_src2  = SRC2_IMM;
                dec_s.alu_ctrl  = ALU_ADD;
                ill_s           = (funct3_s != 3'b000);
            end
            OPC_BRANCH: begin
                dec_s.reg_read = 2'b11;
                dec_s.imm_type = IMM_B;
                case (funct3_s)
                    3'b000:  dec_s.branch_type = BR_BEQ;
                    3'b001:  dec_s.branch_type = BR_BNE;
                    3'b100:  dec_s.branch_type = BR_BLT;
                    3'b101:  dec_s.branch_type = BR_BGE;
                    3'b110:  dec_s.branch_type = BR_BLTU;
                    3'b111:  dec_s.branch_type = BR_BGEU;
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_s.mem_to_reg = 1'b1;
                dec_s.reg_read   = 2'b10;
                dec_s.imm_type   = IMM_I;
                dec_s.alu_src2   = SRC2_IMM;
                dec_s.alu_ctrl   = ALU_ADD;
                case (funct3_s)
                    3'b000:  dec_s.reg_write = RW_LB;
                    3'b001:  dec_s.reg_write = RW_LH;
                    3'b010:  dec_s.reg_write = RW_LW;
                    3'b100:  dec_s.reg_write = RW_LBU;
                    3'b101:  dec_s.reg_write = RW_LHU;
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_s.reg_read = 2'b11;
                dec_s.imm_type = IMM_S;
                dec_s.alu_src2 = SRC2_IMM;
                dec_s.alu_ctrl = ALU_ADD;
                case (funct3_s)
                    3'b000:  dec_s.mem_write = 4'b0001;
                    3'b001:  dec_s.mem_write = 4'b0011;
                    3'b010:  dec_s.mem_write = 4'b1111;
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec_s.reg_write = RW_LW;
                dec_s.reg_read  = 2'b10;
                dec_s.imm_type  = IMM_I;
                dec_s.alu_src2  = SRC2_IMM;
                case (funct3_s)
                    3'b000: dec_s.alu_ctrl = ALU_ADD;
                    3'b010: dec_s.alu_ctrl = ALU_SLT;
                    3'b011: dec_s.alu_ctrl = ALU_SLTU;
                    3'b100: dec_s.alu_ctrl = ALU_XOR;
                    3'b110: dec_s.alu_ctrl = ALU_OR;
                    3'b111: dec_s.alu_ctrl = ALU_AND;
                    3'b001: begin
                        dec_s.alu_src2 = SRC2_SHAMT;
                        dec_s.alu_ctrl = ALU_SLL;
                        ill_s          = (funct7_s != F7_ZERO);
                    end
                    3'b101: begin
                        dec_s.alu_src2 = SRC2_SHAMT;
                        if (funct7_s == F7_ZERO) begin
                            dec_s.alu_ctrl = ALU_SRL;
                        end else if (funct7_s == F7_ALT) begin
                            dec_s.alu_ctrl = ALU_SRA;
                        end else begin
                            ill_s = 1'b1;
                        end
                    end
                    default: ill_s = 1'b1;
                endcase
            end
            OPC_OP: begin
                dec_s.reg_write = RW_LW;
                dec_s.reg_read  = 2'b11;
                dec_s.imm_type  = IMM_R;
                dec_s.alu_src2  = SRC2_REG;
                if (funct7_s == F7_ZERO) begin
                    case (funct3_s)
                        3'b000:  dec_s.alu_ctrl = ALU_ADD;
                        3'b001:  dec_s.alu_ctrl = ALU_SLL;
                        3'b010:  dec_s.alu_ctrl = ALU_SLT;
                        3'b011:  dec_s.alu_ctrl = ALU_SLTU;
                        3'b100:  dec_s.alu_ctrl = ALU_XOR;
                        3'b101:  dec_s.alu_ctrl = ALU_SRL;
                        3'b110:  dec_s.alu_ctrl = ALU_OR;
                        default: dec_s.alu_ctrl = ALU_AND;
                    endcase
                end else if (funct7_s == F7_ALT) begin
                    case (funct3_s)
                        3'b000:  dec_s.alu_ctrl = ALU_SUB;
                        3'b101:  dec_s.alu_ctrl = ALU_SRA;
                        default: ill_s = 1'b1;
                    endcase
                end else if (funct7_s == F7_MULDIV) begin
`ifdef RV32M_EN
                    dec_s.md_op    = {1'b1, funct3_s};
                    dec_s.alu_ctrl = 4'd0;
`else
                    ill_s = 1'b1;
`endif
                end else begin
                    ill_s = 1'b1;
                end
            end
            OPC_MISC: ill_s = (funct3_s != 3'b000) && (funct3_s != 3'b001);
            default:  ill_s = 1'b1;
        endcase
        // Register indices stay raw even when the encoding is rejected.
        if (ill_s) begin
            dec_s         = '0;
            dec_s.pc      = bus.in_pc;
            dec_s.rd      = bus.in_instr[11:7];
            dec_s.rs1     = bus.in_instr[19:15];
            dec_s.rs2     = bus.in_instr[24:20];
            dec_s.illegal = 1'b1;
        end else begin
            dec_s.illegal = 1'b0;
        end
    end

    // Output/skid FSM, next-register values and the saturating illegal counter.
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        cnt_d    = cnt_q;
        accept_s = bus.in_valid && in_ready_q;
        drain_s  = out_valid_q && bus.out_ready;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_d  = dec_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        main_d = dec_s;
                    end else if (accept_s) begin
                        skid_d  = dec_s;
                        state_d = ST_TWO;
                    end else if (drain_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (drain_s) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
            if (accept_s && dec_s.illegal && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    // State, bundle registers and counter; reset clears everything without a clock.
    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_pc          = main_q.pc;
    assign bus.out_rd          = main_q.rd;
    assign bus.out_rs1         = main_q.rs1;
    assign bus.out_rs2         = main_q.rs2;
    assign bus.out_jal         = main_q.jal;
    assign bus.out_jalr        = main_q.jalr;
    assign bus.out_mem_to_reg  = main_q.mem_to_reg;
    assign bus.out_load_npc    = main_q.load_npc;
    assign bus.out_alu_src1    = main_q.alu_src1;
    assign bus.out_reg_write   = main_q.reg_write;
    assign bus.out_mem_write   = main_q.mem_write;
    assign bus.out_reg_read    = main_q.reg_read;
    assign bus.out_branch_type = main_q.branch_type;
    assign bus.out_alu_ctrl    = main_q.alu_ctrl;
    assign bus.out_alu_src2    = main_q.alu_src2;
    assign bus.out_imm_type    = main_q.imm_type;
    assign bus.out_md_op       = main_q.md_op;
    assign bus.out_illegal     = main_q.illegal;
    assign bus.illegal_cnt     = cnt_q;
endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: a queue-based model of the two-entry stage plus a
// table-driven RV32I decoder, compared every cycle, and hand-computed literal checks.
module tb_id_decode_stage;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        jal;
        logic        jalr;
        logic        mem_to_reg;
        logic        load_npc;
        logic        alu_src1;
        logic [2:0]  reg_write;
        logic [3:0]  mem_write;
        logic [1:0]  reg_read;
        logic [2:0]  branch_type;
        logic [3:0]  alu_ctrl;
        logic [1:0]  alu_src2;
        logic [2:0]  imm_type;
        logic [3:0]  md_op;
        logic        illegal;
    } exp_t;

    // Reference encodings: reg-write modes, branch types, ALU ops by funct3.
    localparam logic [2:0] LOAD_MODE [8] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd5, 3'd0, 3'd0};
    localparam logic [2:0] BR_TYPE   [8] = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd5, 3'd4, 3'd6};
    localparam logic [3:0] ST_MASK   [8] = '{4'b0001, 4'b0011, 4'b1111, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    localparam logic [3:0] ALU_BY_F3 [8] = '{4'd3, 4'd0, 4'd8, 4'd9, 4'd5, 4'd1, 4'd6, 4'd7};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    id_decode_stage_if #(.PC_W(32), .CNT_W(CNT_W)) bus ();
    id_decode_stage #(.PC_W(32), .CNT_W(CNT_W)) dut (.CPU_CLK(clk), .CPU_RST(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic ok;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        e = '0;
        ok = 1'b1;
        if (op == 7'h37) begin
            e.reg_write = 3'd3; e.imm_type = 3'd4; e.alu_src2 = 2'd2; e.alu_ctrl = 4'd10;
        end else if (op == 7'h17) begin
            e.reg_write = 3'd3; e.imm_type = 3'd4; e.alu_src1 = 1'b1; e.alu_src2 = 2'd2; e.alu_ctrl = 4'd3;
        end else if (op == 7'h6F) begin
            e.jal = 1'b1; e.load_npc = 1'b1; e.reg_write = 3'd3; e.imm_type = 3'd5;
        end else if (op == 7'h67) begin
            e.jalr = 1'b1; e.load_npc = 1'b1; e.reg_write = 3'd3; e.reg_read = 2'b10;
            e.imm_type = 3'd1; e.alu_src2 = 2'd2; e.alu_ctrl = 4'd3;
            ok = (f3 == 3'd0);
        end else if (op == 7'h63) begin
            e.reg_read = 2'b11; e.imm_type = 3'd3; e.branch_type = BR_TYPE[f3];
            ok = (BR_TYPE[f3] != 3'd0);
        end else if (op == 7'h03) begin
            e.mem_to_reg = 1'b1; e.reg_read = 2'b10; e.imm_type = 3'd1; e.alu_src2 = 2'd2;
            e.alu_ctrl = 4'd3; e.reg_write = LOAD_MODE[f3];
            ok = (LOAD_MODE[f3] != 3'd0);
        end else if (op == 7'h23) begin
            e.reg_read = 2'b11; e.imm_type = 3'd2; e.alu_src2 = 2'd2; e.alu_ctrl = 4'd3;
            e.mem_write = ST_MASK[f3];
            ok = (ST_MASK[f3] != 4'd0);
        end else if (op == 7'h13) begin
            e.reg_write = 3'd3; e.reg_read = 2'b10; e.imm_type = 3'd1;
            e.alu_src2 = (f3 == 3'd1 || f3 == 3'd5) ? 2'd1 : 2'd2;
            e.alu_ctrl = ALU_BY_F3[f3];
            if (f3 == 3'd1) ok = (f7 == 7'h00);
            if (f3 == 3'd5) begin
                ok = (f7 == 7'h00) || (f7 == 7'h20);
                if (f7 == 7'h20) e.alu_ctrl = 4'd2;
            end
        end else if (op == 7'h33) begin
            e.reg_write = 3'd3; e.reg_read = 2'b11;
            if (f7 == 7'h00) e.alu_ctrl = ALU_BY_F3[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) e.alu_ctrl = 4'd4;
            else if (f7 == 7'h20 && f3 == 3'd5) e.alu_ctrl = 4'd2;
`ifdef RV32M_EN
            else if (f7 == 7'h01) e.md_op = {1'b1, f3};
`endif
            else ok = 1'b0;
        end else if (op == 7'h0F) begin
            ok = (f3 <= 3'd1);
        end else begin
            ok = 1'b0;
        end
        if (!ok) e = '0;
        e.illegal = !ok;
        e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        return e;
    endfunction

    exp_t        mq[$];
    int          mcnt = 0;
    logic [31:0] delivered[$];

    // Model update on each edge, from the inputs IF/EX presented in that cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            logic acc, drn;
            acc = bus.in_valid && (mq.size() < 2);
            drn = (mq.size() > 0) && bus.out_ready;
            if (bus.flush) begin
                mq.delete();
            end else begin
                exp_t e;
                e = model_decode(bus.in_instr, bus.in_pc);
                if (drn) void'(mq.pop_front());
                if (acc) begin
                    mq.push_back(e);
                    if (e.illegal && mcnt < CNT_MAX) mcnt++;
                end
            end
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t act;
            act.pc = bus.out_pc; act.rd = bus.out_rd; act.rs1 = bus.out_rs1; act.rs2 = bus.out_rs2;
            act.jal = bus.out_jal; act.jalr = bus.out_jalr; act.mem_to_reg = bus.out_mem_to_reg;
            act.load_npc = bus.out_load_npc; act.alu_src1 = bus.out_alu_src1;
            act.reg_write = bus.out_reg_write; act.mem_write = bus.out_mem_write;
            act.reg_read = bus.out_reg_read; act.branch_type = bus.out_branch_type;
            act.alu_ctrl = bus.out_alu_ctrl; act.alu_src2 = bus.out_alu_src2;
            act.imm_type = bus.out_imm_type; act.md_op = bus.out_md_op; act.illegal = bus.out_illegal;
            check("out_valid", 96'(bus.out_valid), 96'(mq.size() > 0));
            check("in_ready", 96'(bus.in_ready), 96'(mq.size() < 2));
            check("illegal_cnt", 96'(bus.illegal_cnt), 96'(mcnt));
            if (mq.size() > 0) check("bundle", 96'(act), 96'(mq[0]));
            if (bus.out_valid && bus.out_ready) delivered.push_back(bus.out_pc);
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc;
        bus.out_ready = ordy; bus.flush = fl;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SW  = 32'h00512423;
    localparam logic [31:0] I_MUL = 32'h023100B3;
    localparam logic [31:0] I_BAD = 32'hFFFFFFFF;
    localparam logic [31:0] VEC [15] = '{
        32'h12345237, 32'h00001297, 32'h008000EF, 32'h00008067, 32'h00208463,
        32'h0000A183, 32'h0000B183, 32'h00A08093, 32'h4020D093, 32'h402081B3,
        32'h0000000F, 32'h0000200F, 32'h0020A063, 32'h00209093, 32'h02209093};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0;
        bus.out_ready = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 96'(bus.out_valid), 96'(0));
        check("rst_in_ready", 96'(bus.in_ready), 96'(1));
        check("rst_fields", 96'({bus.out_pc, bus.out_rd, bus.out_alu_ctrl, bus.out_reg_write,
                                 bus.out_mem_write, bus.out_md_op, bus.out_illegal}), 96'(0));
        check("rst_cnt", 96'(bus.illegal_cnt), 96'(0));
        rst = 1'b0;

        // add x3,x1,x2 then sw x5,8(x2), streaming with out_ready high
        step(1'b1, I_ADD, 32'h100, 1'b1, 1'b0);
        check("add_valid", 96'(bus.out_valid), 96'(1));
        check("add_regs", 96'({bus.out_rd, bus.out_rs1, bus.out_rs2}), 96'({5'd3, 5'd1, 5'd2}));
        check("add_alu", 96'(bus.out_alu_ctrl), 96'(3));
        check("add_rr", 96'(bus.out_reg_read), 96'(2'b11));
        check("add_ill", 96'(bus.out_illegal), 96'(0));
        step(1'b1, I_SW, 32'h104, 1'b1, 1'b0);
        check("sw_mw", 96'(bus.out_mem_write), 96'(4'b1111));
        check("sw_imm", 96'(bus.out_imm_type), 96'(2));
        check("sw_rw", 96'(bus.out_reg_write), 96'(0));
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // back-pressure: three back-to-back with EX stalled, then release
        delivered.delete();
        step(1'b1, I_ADD, 32'h200, 1'b0, 1'b0);
        check("bp_ready1", 96'(bus.in_ready), 96'(1));
        step(1'b1, I_SW, 32'h204, 1'b0, 1'b0);
        check("bp_ready2", 96'(bus.in_ready), 96'(0));
        step(1'b1, 32'h00A08093, 32'h208, 1'b0, 1'b0);
        step(1'b1, 32'h00A08093, 32'h208, 1'b1, 1'b0);
        step(1'b1, 32'h00A08093, 32'h208, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("bp_count", 96'(delivered.size()), 96'(3));
        if (delivered.size() == 3)
            check("bp_order", 96'({delivered[0], delivered[1], delivered[2]}),
                  96'({32'h200, 32'h204, 32'h208}));

        // flush while full with a new instruction offered
        step(1'b1, I_ADD, 32'h300, 1'b0, 1'b0);
        step(1'b1, I_SW, 32'h304, 1'b0, 1'b0);
        step(1'b1, I_ADD, 32'h308, 1'b0, 1'b1);
        check("fl_valid", 96'(bus.out_valid), 96'(0));
        check("fl_ready", 96'(bus.in_ready), 96'(1));
        delivered.delete();
        repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("fl_none_out", 96'(delivered.size()), 96'(0));

        // decode table with a stuttering out_ready
        begin
            int idx = 0;
            int guard = 0;
            while (idx < 15 && guard < 200) begin
                logic rdy;
                rdy = bus.in_ready;
                step(1'b1, VEC[idx], 32'h400 + 32'(idx * 4), (guard % 3) != 2, 1'b0);
                if (rdy) idx++;
                guard++;
            end
            check("vec_done", 96'(idx), 96'(15));
            repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        end

        // asynchronous reset in the middle of a full stage
        step(1'b1, I_ADD, 32'h500, 1'b0, 1'b0);
        step(1'b1, I_BAD, 32'h504, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("arst_valid", 96'(bus.out_valid), 96'(0));
        check("arst_ready", 96'(bus.in_ready), 96'(1));
        check("arst_fields", 96'({bus.out_pc, bus.out_rd, bus.out_rs1}), 96'(0));
        check("arst_cnt", 96'(bus.illegal_cnt), 96'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // illegal instructions and counter saturation
        step(1'b1, I_BAD, 32'h600, 1'b1, 1'b0);
        check("bad_ill", 96'(bus.out_illegal), 96'(1));
        check("bad_se", 96'({bus.out_reg_write, bus.out_mem_write, bus.out_jal, bus.out_jalr,
                             bus.out_branch_type, bus.out_reg_read}), 96'(0));
        step(1'b1, I_BAD, 32'h604, 1'b1, 1'b0);
        check("bad_ill2", 96'(bus.out_illegal), 96'(1));
        check("bad_cnt2", 96'(bus.illegal_cnt), 96'(2));
        repeat (3) step(1'b1, I_BAD, 32'h608, 1'b1, 1'b0);
        check("bad_sat", 96'(bus.illegal_cnt), 96'(3));

        // mul x1,x2,x3
        step(1'b1, I_MUL, 32'h700, 1'b1, 1'b0);
`ifdef RV32M_EN
        check("mul_md", 96'(bus.out_md_op), 96'(4'b1000));
        check("mul_ill", 96'(bus.out_illegal), 96'(0));
`else
        check("mul_md", 96'(bus.out_md_op), 96'(4'b0000));
        check("mul_ill", 96'(bus.out_illegal), 96'(1));
`endif
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
